// File: rtl/intr_arbiter.sv
// Fixed-priority interrupt arbiter: edge-detects up to eight event sources, latches them as
// pending, and issues one PicoBlaze interrupt request at a time, reporting the granted source.
module intr_arbiter #(
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned HOLDOFF_CYCLES = 4
) (
    input  logic               sysclk,
    input  logic               sysreset,
    input  logic [NUM_SRC-1:0] src_event,
    input  logic               mask_wr,
    input  logic [NUM_SRC-1:0] mask_data,
    input  logic               clr_wr,
    input  logic [NUM_SRC-1:0] clr_data,
    input  logic               interrupt_ack,
    output logic               interrupt_request,
    output logic [7:0]         cause,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] overrun,
    output logic [NUM_SRC-1:0] mask
);

    localparam int unsigned CntW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CntW-1:0] HoldoffLoad = CntW'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StReq, StWaitAck, StHoldoff} state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic [NUM_SRC-1:0] prev_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] overrun_q, overrun_d;
    logic [NUM_SRC-1:0] mask_q;
    logic [2:0]         grant_q;
    logic               in_service_q;
    logic               req_q;

    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr_vec;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] elig;
    logic [2:0]         grant_idx;
    logic               ack_fire;

    assign rise     = src_event & ~prev_q;
    assign clr_vec  = {NUM_SRC{clr_wr}} & clr_data;
    assign elig     = pending_q & ~mask_q;
    assign ack_fire = (state_q == StWaitAck) && interrupt_ack;

    // Lowest index wins; indices at or above NUM_SRC simply do not exist here.
    always_comb begin
        grant_idx = 3'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (elig[i]) grant_idx = 3'(i);
        end
    end

    always_comb begin
        ack_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (ack_fire && (grant_q == 3'(i))) ack_clr[i] = 1'b1;
        end
    end

    // A same-cycle rise always beats a clear so no event is dropped.
    assign pending_d = rise | (pending_q & ~clr_vec & ~ack_clr);
    assign overrun_d = (rise & pending_q) | (overrun_q & ~clr_vec);

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            prev_q    <= '0;
            pending_q <= '0;
            overrun_q <= '0;
            mask_q    <= '1;
        end else begin
            prev_q    <= src_event;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            if (mask_wr) mask_q <= mask_data;
        end
    end

    always_ff @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            grant_q      <= 3'd0;
            in_service_q <= 1'b0;
            req_q        <= 1'b0;
        end else begin
            req_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (|elig) begin
                        grant_q      <= grant_idx;
                        in_service_q <= 1'b1;
                        req_q        <= 1'b1;
                        state_q      <= StReq;
                    end
                end
                StReq: state_q <= StWaitAck;
                StWaitAck: begin
                    // Mask or clear writes here never cancel the outstanding request.
                    if (interrupt_ack) begin
                        cnt_q   <= HoldoffLoad;
                        state_q <= StHoldoff;
                    end
                end
                StHoldoff: begin
                    if (cnt_q == '0) begin
                        in_service_q <= 1'b0;
                        state_q      <= StIdle;
                    end else begin
                        cnt_q <= cnt_q - CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign interrupt_request = req_q;
    assign cause             = {in_service_q, 4'b0000, grant_q};
    assign pending           = pending_q;
    assign overrun           = overrun_q;
    assign mask              = mask_q;

endmodule

// File: tb/tb_intr_arbiter.sv
// Scoreboard bench for intr_arbiter: expected requests (cause, edge) are queued by the
// stimulus and checked by a monitor whenever interrupt_request is seen.
module tb_intr_arbiter;

    localparam int unsigned NSRC = 4;
    localparam int unsigned HOLD = 4;

    logic            sysclk = 1'b0;
    logic            sysreset = 1'b0;
    logic [NSRC-1:0] src_event = '0;
    logic            mask_wr = 1'b0;
    logic [NSRC-1:0] mask_data = '0;
    logic            clr_wr = 1'b0;
    logic [NSRC-1:0] clr_data = '0;
    logic            interrupt_ack = 1'b0;
    logic            interrupt_request;
    logic [7:0]      cause;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] overrun;
    logic [NSRC-1:0] mask;

    intr_arbiter #(
        .NUM_SRC        (NSRC),
        .HOLDOFF_CYCLES (HOLD)
    ) dut (
        .sysclk            (sysclk),
        .sysreset          (sysreset),
        .src_event         (src_event),
        .mask_wr           (mask_wr),
        .mask_data         (mask_data),
        .clr_wr            (clr_wr),
        .clr_data          (clr_data),
        .interrupt_ack     (interrupt_ack),
        .interrupt_request (interrupt_request),
        .cause             (cause),
        .pending           (pending),
        .overrun           (overrun),
        .mask              (mask)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic [7:0] cause;
        int         edge_n;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   req_count = 0;
    int   acked   = 0;
    int   last_req_edge = 0;
    logic req_prev = 1'b0;
    int   a;

    // Edge counter: value k means the k-th rising edge since reset release has happened.
    always @(posedge sysclk or negedge sysreset) begin
        if (!sysreset) cyc <= 0;
        else           cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_req(input logic [7:0] c, input int e);
        exp_t x;
        x.cause  = c;
        x.edge_n = e;
        exp_q.push_back(x);
    endtask

    // Monitor: every request pulse must match the head of the scoreboard.
    always @(negedge sysclk) begin
        exp_t x;
        if (req_prev) chk("req_one_cycle", 32'(interrupt_request), 32'd0);
        if (interrupt_request) begin
            req_count++;
            last_req_edge = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_req", 32'(cause), 32'hFFFF);
            end else begin
                x = exp_q.pop_front();
                chk("req_cause", 32'(cause), 32'(x.cause));
                chk("req_edge", 32'(cyc), 32'(x.edge_n));
            end
        end
        req_prev = interrupt_request;
    end

    task automatic step();
        @(negedge sysclk);
        #1;
    endtask

    // Wait for the next not-yet-acked request and for the FSM to reach WAIT_ACK.
    task automatic wait_wack();
        int n = 0;
        while (req_count <= acked && n < 60) begin
            step();
            n++;
        end
        if (req_count <= acked) chk("req_timeout", 32'(req_count), 32'(acked + 1));
        acked++;
        while (cyc < last_req_edge + 1) step();
    endtask

    task automatic ack(output int ack_edge);
        interrupt_ack = 1'b1;
        ack_edge = cyc + 1;
        step();
        interrupt_ack = 1'b0;
    endtask

    task automatic write_mask(input logic [NSRC-1:0] m);
        mask_wr   = 1'b1;
        mask_data = m;
        step();
        mask_wr   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) step();
        sysreset = 1'b1;
        step();

        // Reset defaults, and an event under the reset mask never requests.
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        chk("rst_mask", 32'(mask), 32'hF);
        chk("rst_cause", 32'(cause), 32'h00);
        chk("rst_req", 32'(interrupt_request), 32'h0);
        src_event = 4'b0100;
        step();
        src_event = 4'b0000;
        step();
        chk("masked_pending", 32'(pending), 32'h4);
        chk("masked_mask", 32'(mask), 32'hF);
        chk("masked_cause", 32'(cause), 32'h00);
        repeat (6) step();
        clr_wr = 1'b1;
        clr_data = 4'b0100;
        step();
        clr_wr = 1'b0;
        chk("masked_clr", 32'(pending), 32'h0);

        // Single source: request one edge after the pending edge, cause[7] drops after holdoff.
        write_mask(4'b0000);
        chk("mask_write", 32'(mask), 32'h0);
        src_event = 4'b0010;
        push_req(8'h81, cyc + 2);
        step();
        chk("single_pending", 32'(pending), 32'h2);
        src_event = 4'b0000;
        wait_wack();
        chk("single_wait_cause", 32'(cause), 32'h81);
        ack(a);
        chk("single_ack_pending", 32'(pending), 32'h0);
        repeat (3) step();
        chk("single_holdoff_cause", 32'(cause), 32'h81);
        step();
        chk("single_idle_cause", 32'(cause), 32'h01);

        // Priority: src0 before src3, second request HOLD+1 edges after the first ack.
        repeat (3) step();
        src_event = 4'b1001;
        push_req(8'h80, cyc + 2);
        step();
        src_event = 4'b0000;
        wait_wack();
        ack(a);
        push_req(8'h83, a + HOLD + 1);
        chk("prio_pending", 32'(pending), 32'h8);
        wait_wack();
        ack(a);
        chk("prio_drained", 32'(pending), 32'h0);

        // Overrun: second rise while pending; ack keeps it, clr_wr removes it.
        repeat (6) step();
        src_event = 4'b0100;
        push_req(8'h82, cyc + 2);
        step();
        src_event = 4'b0000;
        step();
        src_event = 4'b0100;
        step();
        src_event = 4'b0000;
        chk("ovr_set", 32'(overrun), 32'h4);
        wait_wack();
        ack(a);
        chk("ovr_after_ack", 32'(overrun), 32'h4);
        chk("ovr_ack_pending", 32'(pending), 32'h0);
        clr_wr = 1'b1;
        clr_data = 4'b0100;
        step();
        clr_wr = 1'b0;
        chk("ovr_clr_overrun", 32'(overrun), 32'h0);
        chk("ovr_clr_pending", 32'(pending), 32'h0);

        // Set beats clear; masking during WAIT_ACK does not stop the ack.
        repeat (6) step();
        src_event = 4'b0010;
        clr_wr = 1'b1;
        clr_data = 4'b0010;
        push_req(8'h81, cyc + 2);
        step();
        src_event = 4'b0000;
        clr_wr = 1'b0;
        chk("setwin_pending", 32'(pending), 32'h2);
        wait_wack();
        write_mask(4'b0010);
        chk("wack_mask", 32'(mask), 32'h2);
        ack(a);
        chk("wack_ack_pending", 32'(pending), 32'h0);
        chk("wack_holdoff_cause", 32'(cause), 32'h81);
        repeat (HOLD) step();
        chk("wack_idle_cause", 32'(cause), 32'h01);
        write_mask(4'b0000);

        // Mid-service reset clears everything without a clock edge.
        repeat (6) step();
        src_event = 4'b1010;
        push_req(8'h81, cyc + 2);
        step();
        src_event = 4'b0000;
        wait_wack();
        chk("mid_pending", 32'(pending), 32'hA);
        #2 sysreset = 1'b0;
        #1;
        chk("mid_rst_pending", 32'(pending), 32'h0);
        chk("mid_rst_overrun", 32'(overrun), 32'h0);
        chk("mid_rst_mask", 32'(mask), 32'hF);
        chk("mid_rst_cause", 32'(cause), 32'h00);
        chk("mid_rst_req", 32'(interrupt_request), 32'h0);
        step();
        step();
        sysreset = 1'b1;
        repeat (8) step();
        chk("post_rst_pending", 32'(pending), 32'h0);
        src_event = 4'b0001;
        step();
        src_event = 4'b0000;
        chk("post_rst_event", 32'(pending), 32'h1);
        repeat (5) step();
        chk("post_rst_no_req", 32'(req_count), 32'(acked));
        push_req(8'h80, cyc + 2);
        write_mask(4'b0000);
        wait_wack();
        ack(a);
        chk("post_rst_ack", 32'(pending), 32'h0);
        repeat (HOLD + 4) step();

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/intr_arbiter.md
# intr_arbiter

Interrupt controller that shares the PicoBlaze's single interrupt line among up to eight event sources, such as Rojobot update ticks, debounced buttons and timers. It edge-detects source events, latches them as pending, and applies a software-written mask. It grants the lowest-index eligible source and drives the `interrupt_request` input of `nexys4_if`, one request at a time. A cause byte, exposed on an input port, tells the ISR which source was serviced.

## Interface
- `NUM_SRC`, default 4: number of sources; legal range 1..8.
- `HOLDOFF_CYCLES`, default 4: minimum number of cycles from an ack to the next IDLE state; must be ≥1.

Ports:
- `sysclk`, in, 1: system clock; all state is on its rising edge.
- `sysreset`, in, 1: reset, asynchronous and active-low.
- `src_event`, in, NUM_SRC: source event levels, synchronous to `sysclk`; rising edges are counted.
- `mask_wr`, in, 1: when high, loads `mask_data` into the mask register.
- `mask_data`, in, NUM_SRC: 1 = masked.
- `clr_wr`, in, 1: when high, write-1-to-clear `pending` and `overrun`.
- `clr_data`, in, NUM_SRC: bits to clear.
- `interrupt_ack`, in, 1: PicoBlaze interrupt acknowledge.
- `interrupt_request`, out, 1: one-cycle request pulse to `nexys4_if`.
- `cause`, out, 8: bit 7 = `in_service`, bits 6:3 = 0, bits 2:0 = granted source index.
- `pending`, out, NUM_SRC: latched events not yet serviced.
- `overrun`, out, NUM_SRC: sticky flag, set when an event arrives while its source is already pending.
- `mask`, out, NUM_SRC: current mask register.

## Operation
**Reset values:** `pending`=0, `overrun`=0, `mask`=all ones, `cause`=0, `interrupt_request`=0, edge-detect history=0, state=IDLE, holdoff counter=0.

**Edge detect:** `rise = src_event & ~prev`; `prev <= src_event` every cycle.

**Pending update (per bit, each edge):**
- If `rise`, set to 1. Set wins over a same-cycle `clr_wr` or ack clear, so no event is lost.
- Otherwise clear to 0 if `clr_wr & clr_data[i]`, or on an ack while `i` is the granted source.

**Overrun:**
- Set when `rise[i]` occurs while `pending[i]` is already 1.
- Cleared by `clr_wr & clr_data[i]`; a same-cycle set wins.
- An ack does not clear it.

**Eligibility and grant:**
- Eligible sources are `pending & ~mask`. Fixed priority: index 0 is highest.

**FSM (2-bit):**
- IDLE: if any source is eligible, latch the grant index into `cause[2:0]`, set `cause[7]`, and go to REQ.
- REQ: `interrupt_request`=1 for exactly this one cycle; go to WAIT_ACK unconditionally.
- WAIT_ACK: hold until `interrupt_ack`=1. On the ack, clear `pending[grant]`, load the counter with HOLDOFF_CYCLES-1, and go to HOLDOFF.
- HOLDOFF: decrement the counter. When it is 0, go to IDLE and clear `cause[7]`.

**Rules during service:**
- `interrupt_ack` is ignored in IDLE, REQ and HOLDOFF.
- While in WAIT_ACK, mask writes and `clr_wr` on the granted source do not cancel the outstanding request. The FSM still waits for the ack.
- `cause[2:0]` holds its value until the next grant; it is not cleared on return to IDLE.
- A source index greater than or equal to NUM_SRC is never granted.

## Timing
- `interrupt_request` is registered, as is `cause`.
- **Event to request:** a rise sampled at edge k sets `pending` at edge k. The FSM enters REQ at edge k+1, so `interrupt_request` is high from k+1 to k+2.
- **Ack to next grant:** an ack sampled at edge a gives HOLDOFF from a, IDLE at a+HOLDOFF_CYCLES, and the earliest next REQ at a+HOLDOFF_CYCLES+1.
- **Mask writes:** take effect on the next IDLE evaluation, one edge after the write.
- **Reset:** asserting `sysreset` in any state clears everything immediately, without waiting for a clock, including a request pulse in flight. Release is sampled at the next `sysclk` edge.

## Test plan
- **Reset defaults:** reset, then pulse `src_event`[2] with the mask still at reset → `pending`=4'b0100, `mask`=4'b1111, `cause`=0x00, `interrupt_request` never asserted.
- **Single source:** write mask 4'b0000, rise on src1 at edge 5 → `pending`=4'b0010 at edge 5. `interrupt_request` is high for exactly one cycle starting edge 6, with `cause`=0x81. Ack at edge 12 → `pending`=0 at edge 12, `cause`=0x01 at edge 16.
- **Priority:** src0 and src3 rise together → first grant gives `cause`=0x80. After its ack at edge a, the second REQ is at a+5 with `cause`=0x83.
- **Overrun:** src2 rises twice before the ack → `overrun`=4'b0100, and the ack leaves it set. Then `clr_wr` with 4'b0100 → `pending[2]`=0 and `overrun[2]`=0.
- **Set vs. clear:** rise on src1 in the same cycle as `clr_wr` with 4'b0010 → `pending[1]`=1. Mask src1 during WAIT_ACK → the ack is still accepted and the FSM moves to HOLDOFF.
- **Mid-service reset:** assert `sysreset` during WAIT_ACK with `pending`=4'b1010 → all outputs return to reset values within the same cycle. After release, no request is issued until a new event arrives and the mask is cleared.
